// File: rtl/video_pkg.sv
// Shared types and constants for the video timing generator.
package video_pkg;

   // Phase of one raster axis (horizontal or vertical).
   typedef enum logic [1:0] {ACT, FP, SYN, BP} axis_state_t;

   localparam int COORD_W   = 12;
   localparam int MAX_TOTAL = 4096;

   // 640x480@60 timing.
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   // Colour bars {r,g,b}, index 0 is the leftmost bar:
   // white, yellow, cyan, green, magenta, red, blue, black.
   localparam logic [7:0][23:0] COLOUR_BARS = {
      24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
      24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
   };

   // Phase order along an axis; BP returns to ACT.
   function automatic axis_state_t next_axis_state(input axis_state_t s);
      case (s)
         ACT:     return FP;
         FP:      return SYN;
         SYN:     return BP;
         default: return ACT;
      endcase
   endfunction

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: phase FSM with a per-phase down-counter plus a raw
// position counter. Advances only when en is high; wrap flags the last
// position of the axis on an enabled cycle.
module video_axis_counter
   import video_pkg::*;
#(
   parameter int ACT_LEN = DEF_H_ACTIVE,
   parameter int FP_LEN  = DEF_H_FP,
   parameter int SYN_LEN = DEF_H_SYNC,
   parameter int BP_LEN  = DEF_H_BP
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   output axis_state_t        state,
   output logic [COORD_W-1:0] count,
   output logic               wrap
);

   localparam int TOTAL = ACT_LEN + FP_LEN + SYN_LEN + BP_LEN;
   localparam logic [COORD_W-1:0] ONE  = COORD_W'(1);
   localparam logic [COORD_W-1:0] LAST = COORD_W'(TOTAL - 1);

   axis_state_t        state_q, state_d;
   logic [COORD_W-1:0] rem_q, rem_d;
   logic [COORD_W-1:0] cnt_q, cnt_d;

   function automatic logic [COORD_W-1:0] len_of(input axis_state_t s);
      case (s)
         ACT:     return COORD_W'(ACT_LEN);
         FP:      return COORD_W'(FP_LEN);
         SYN:     return COORD_W'(SYN_LEN);
         default: return COORD_W'(BP_LEN);
      endcase
   endfunction

   // State, phase down-counter and position registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ACT;
         rem_q   <= COORD_W'(ACT_LEN);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: leave a phase when its remaining count reaches 1, so a
   // phase of length 1 lasts exactly one step.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      wrap    = en && (cnt_q == LAST);
      if (en) begin
         cnt_d = wrap ? '0 : cnt_q + ONE;
         if (rem_q == ONE) begin
            state_d = next_axis_state(state_q);
            rem_d   = len_of(state_d);
         end else begin
            rem_d = rem_q - ONE;
         end
      end
   end

   assign state = state_q;
   assign count = cnt_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator for the DVI output path: de, syncs, coordinates,
// line/frame strobes and an optional colour-bar pattern. All outputs are
// registered one cycle behind the internal counters so they stay aligned.
// Build option: define VIDEO_TEST_PATTERN_EN to enable the colour bars.
module video_timing_gen
   import video_pkg::*;
#(
   parameter int   H_ACTIVE  = DEF_H_ACTIVE,
   parameter int   H_FP      = DEF_H_FP,
   parameter int   H_SYNC    = DEF_H_SYNC,
   parameter int   H_BP      = DEF_H_BP,
   parameter int   V_ACTIVE  = DEF_V_ACTIVE,
   parameter int   V_FP      = DEF_V_FP,
   parameter int   V_SYNC    = DEF_V_SYNC,
   parameter int   V_BP      = DEF_V_BP,
   parameter logic HSYNC_POL = 1'b0,
   parameter logic VSYNC_POL = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   output logic               de,
   output logic               hsync,
   output logic               vsync,
   output logic [1:0]         ctrl0,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               line_start,
   output logic               frame_start,
   output logic [7:0]         red,
   output logic [7:0]         grn,
   output logic [7:0]         blu
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_chk
      $error("video_timing_gen: H_TOTAL/V_TOTAL exceed 4096");
   end
   if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_min_chk
      $error("video_timing_gen: every timing parameter must be >= 1");
   end

   axis_state_t        h_state, v_state;
   logic [COORD_W-1:0] hx, vy;
   logic               h_wrap, v_wrap;

   video_axis_counter #(
      .ACT_LEN(H_ACTIVE), .FP_LEN(H_FP), .SYN_LEN(H_SYNC), .BP_LEN(H_BP)
   ) u_h (
      .clk(clk), .rst(rst), .en(1'b1),
      .state(h_state), .count(hx), .wrap(h_wrap)
   );

   video_axis_counter #(
      .ACT_LEN(V_ACTIVE), .FP_LEN(V_FP), .SYN_LEN(V_SYNC), .BP_LEN(V_BP)
   ) u_v (
      .clk(clk), .rst(rst), .en(h_wrap),
      .state(v_state), .count(vy), .wrap(v_wrap)
   );

   // The wraps announce that the next internal position is x==0 (and y==0);
   // after reset the internal position already is (0,0), hence reset to 1.
   logic line_pend_q, line_pend_d;
   logic frame_pend_q, frame_pend_d;

   // Pending strobe flags, one cycle ahead of the output stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_pend_q  <= 1'b1;
         frame_pend_q <= 1'b1;
      end else begin
         line_pend_q  <= line_pend_d;
         frame_pend_q <= frame_pend_d;
      end
   end

   // Pending flags track the wrap strobes.
   always_comb begin
      line_pend_d  = h_wrap;
      frame_pend_d = v_wrap;
   end

   logic               de_q, de_d;
   logic               hsync_q, hsync_d;
   logic               vsync_q, vsync_d;
   logic [COORD_W-1:0] x_q, x_d;
   logic [COORD_W-1:0] y_q, y_d;
   logic               line_start_q, line_start_d;
   logic               frame_start_q, frame_start_d;

   // Decode of the current internal position into output levels.
   always_comb begin
      de_d          = (h_state == ACT) && (v_state == ACT);
      hsync_d       = (h_state == SYN) ? HSYNC_POL : ~HSYNC_POL;
      vsync_d       = (v_state == SYN) ? VSYNC_POL : ~VSYNC_POL;
      x_d           = hx;
      y_d           = vy;
      line_start_d  = line_pend_q;
      frame_start_d = frame_pend_q;
   end

   // Output stage; reset drives sync lines to their inactive level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         de_q          <= 1'b0;
         hsync_q       <= ~HSYNC_POL;
         vsync_q       <= ~VSYNC_POL;
         x_q           <= '0;
         y_q           <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         de_q          <= de_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         x_q           <= x_d;
         y_q           <= y_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign de          = de_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign ctrl0       = {vsync_q, hsync_q};
   assign x           = x_q;
   assign y           = y_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

`ifdef VIDEO_TEST_PATTERN_EN
   // Narrow rasters (H_ACTIVE < 8) would give a zero bar width; use 1-pixel
   // bars there so the counter still steps.
   localparam int BAR_W = (H_ACTIVE / 8 < 1) ? 1 : H_ACTIVE / 8;
   localparam logic [COORD_W-1:0] BAR_LAST = COORD_W'(BAR_W - 1);
   localparam logic [COORD_W-1:0] PIX_ONE  = COORD_W'(1);

   logic [COORD_W-1:0] bar_pix_q, bar_pix_d;
   logic [2:0]         bar_idx_q, bar_idx_d;
   logic [23:0]        rgb_q, rgb_d;

   // Bar position tracker plus pattern output stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bar_pix_q <= '0;
         bar_idx_q <= '0;
         rgb_q     <= '0;
      end else begin
         bar_pix_q <= bar_pix_d;
         bar_idx_q <= bar_idx_d;
         rgb_q     <= rgb_d;
      end
   end

   // Bar index follows the internal x: restart on line wrap, step every
   // BAR_W pixels, and stick at the last bar so remainder pixels join it.
   always_comb begin
      bar_pix_d = bar_pix_q;
      bar_idx_d = bar_idx_q;
      if (h_wrap) begin
         bar_pix_d = '0;
         bar_idx_d = '0;
      end else if (bar_pix_q == BAR_LAST) begin
         bar_pix_d = '0;
         if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
      end else begin
         bar_pix_d = bar_pix_q + PIX_ONE;
      end
      rgb_d = de_d ? COLOUR_BARS[bar_idx_q] : 24'h000000;
   end

   assign red = rgb_q[23:16];
   assign grn = rgb_q[15:8];
   assign blu = rgb_q[7:0];
`else
   assign red = 8'h00;
   assign grn = 8'h00;
   assign blu = 8'h00;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: three instances (default
// 640x480, minimal 7x5 with active-high syncs, full-width line with a short
// frame) compared every cycle against a position-arithmetic model.
module tb_video_timing_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        de_o [3];
   logic        hs_o [3];
   logic        vs_o [3];
   logic [1:0]  c0_o [3];
   logic [11:0] x_o  [3];
   logic [11:0] y_o  [3];
   logic        ls_o [3];
   logic        fs_o [3];
   logic [7:0]  r_o  [3];
   logic [7:0]  g_o  [3];
   logic [7:0]  b_o  [3];

   int     checks = 0;
   int     errors = 0;
   longint ecount;
   int     de_cnt_med = 0;

   video_timing_gen u_def (
      .clk(clk), .rst(rst), .de(de_o[0]), .hsync(hs_o[0]), .vsync(vs_o[0]),
      .ctrl0(c0_o[0]), .x(x_o[0]), .y(y_o[0]), .line_start(ls_o[0]),
      .frame_start(fs_o[0]), .red(r_o[0]), .grn(g_o[0]), .blu(b_o[0]));

   video_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
      .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
   ) u_min (
      .clk(clk), .rst(rst), .de(de_o[1]), .hsync(hs_o[1]), .vsync(vs_o[1]),
      .ctrl0(c0_o[1]), .x(x_o[1]), .y(y_o[1]), .line_start(ls_o[1]),
      .frame_start(fs_o[1]), .red(r_o[1]), .grn(g_o[1]), .blu(b_o[1]));

   video_timing_gen #(
      .V_ACTIVE(20), .V_FP(3), .V_SYNC(2), .V_BP(3)
   ) u_med (
      .clk(clk), .rst(rst), .de(de_o[2]), .hsync(hs_o[2]), .vsync(vs_o[2]),
      .ctrl0(c0_o[2]), .x(x_o[2]), .y(y_o[2]), .line_start(ls_o[2]),
      .frame_start(fs_o[2]), .red(r_o[2]), .grn(g_o[2]), .blu(b_o[2]));

   typedef struct {
      int ha, hfp, hs, hbp, va, vfp, vs, vbp;
      bit hp, vp;
   } cfg_t;

   function automatic cfg_t cfg_of(input int i);
      cfg_t c;
      case (i)
         0:       c = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
         1:       c = '{4, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b1};
         default: c = '{640, 16, 96, 48, 20, 3, 2, 3, 1'b0, 1'b0};
      endcase
      return c;
   endfunction

   function automatic logic [23:0] bar_colour(input int b);
      case (b)
         0:       return 24'hFFFFFF;
         1:       return 24'hFFFF00;
         2:       return 24'h00FFFF;
         3:       return 24'h00FF00;
         4:       return 24'hFF00FF;
         5:       return 24'hFF0000;
         6:       return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   // Expected outputs after e clock edges since reset release (e==0: reset).
   // Those outputs describe raster position t = e-1.
   function automatic logic [54:0] expect_of(input int i, input longint e);
      cfg_t c;
      int ht, vt, t, px, py, bw, bar;
      logic d, h, v;
      logic [23:0] rgb;
      c = cfg_of(i);
      if (e == 0)
         return {1'b0, ~c.hp, ~c.vp, ~c.vp, ~c.hp, 12'd0, 12'd0, 1'b0, 1'b0, 24'd0};
      ht = c.ha + c.hfp + c.hs + c.hbp;
      vt = c.va + c.vfp + c.vs + c.vbp;
      t  = int'(e - 1);
      px = t % ht;
      py = (t / ht) % vt;
      d  = (px < c.ha) && (py < c.va);
      h  = (px >= c.ha + c.hfp && px < c.ha + c.hfp + c.hs) ? c.hp : ~c.hp;
      v  = (py >= c.va + c.vfp && py < c.va + c.vfp + c.vs) ? c.vp : ~c.vp;
      rgb = 24'd0;
`ifdef VIDEO_TEST_PATTERN_EN
      if (d) begin
         bw = c.ha / 8;
         if (bw < 1) bw = 1;
         bar = px / bw;
         if (bar > 7) bar = 7;
         rgb = bar_colour(bar);
      end
`else
      bw  = 0;
      bar = 0;
`endif
      return {d, h, v, v, h, 12'(px), 12'(py), (px == 0), (px == 0 && py == 0), rgb};
   endfunction

   function automatic logic [54:0] actual_of(input int i);
      return {de_o[i], hs_o[i], vs_o[i], c0_o[i], x_o[i], y_o[i],
              ls_o[i], fs_o[i], r_o[i], g_o[i], b_o[i]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, ecount);
      end
   endtask

   // Clock edges since the last reset release.
   always @(posedge clk or posedge rst) begin
      if (rst) ecount <= 0;
      else     ecount <= ecount + 1;
   end

   // Every-cycle comparison of all three instances against the model.
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++)
         chk((i == 0) ? "cycle def" : (i == 1) ? "cycle min" : "cycle med",
             64'(actual_of(i)), 64'(expect_of(i, ecount)));
      if (ecount >= 1 && ecount <= 22400 && de_o[2] === 1'b1)
         de_cnt_med++;
   end

   // Advance to just after the edge whose outputs describe position t.
   task automatic wait_t(input longint t);
      for (int n = 0; n < 100000 && ecount < t + 1; n++) begin
         @(posedge clk);
         #1;
      end
      chk("wait_t reached", ecount, t + 1);
   endtask

   longint tgt;
   int     n;

   initial begin
      rst = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst de", de_o[0], 1'b0);
      chk("rst hsync", hs_o[0], 1'b1);
      chk("rst vsync", vs_o[0], 1'b1);
      chk("rst ctrl0", c0_o[0], 2'b11);
      chk("rst x", x_o[0], 12'd0);
      chk("rst min hsync", hs_o[1], 1'b0);
      rst = 1'b0;

      wait_t(0);
      chk("first x", x_o[0], 12'd0);
      chk("first y", y_o[0], 12'd0);
      chk("first de", de_o[0], 1'b1);
      chk("first line_start", ls_o[0], 1'b1);
      chk("first frame_start", fs_o[0], 1'b1);
`ifdef VIDEO_TEST_PATTERN_EN
      chk("bar x0", {r_o[0], g_o[0], b_o[0]}, 24'hFFFFFF);
`else
      chk("rgb x0", {r_o[0], g_o[0], b_o[0]}, 24'h000000);
`endif
      wait_t(34);
      chk("min last xy", {x_o[1], y_o[1], fs_o[1]}, {12'd6, 12'd4, 1'b0});
      wait_t(35);
      chk("min wrap xy", {x_o[1], y_o[1], fs_o[1]}, {12'd0, 12'd0, 1'b1});
      wait_t(80);
`ifdef VIDEO_TEST_PATTERN_EN
      chk("bar x80", {r_o[0], g_o[0], b_o[0]}, 24'hFFFF00);
`else
      chk("rgb x80", {r_o[0], g_o[0], b_o[0]}, 24'h000000);
`endif
      wait_t(639);
      chk("de x639", de_o[0], 1'b1);
      chk("rgb x639", {r_o[0], g_o[0], b_o[0]}, 24'h000000);
      wait_t(640);
      chk("de x640", de_o[0], 1'b0);
      chk("rgb x640", {r_o[0], g_o[0], b_o[0]}, 24'h000000);
      wait_t(655);
      chk("hsync x655", hs_o[0], 1'b1);
      wait_t(656);
      chk("hsync x656", hs_o[0], 1'b0);
      wait_t(751);
      chk("hsync x751", hs_o[0], 1'b0);
      wait_t(752);
      chk("hsync x752", hs_o[0], 1'b1);
      wait_t(800);
      chk("line2 xy", {x_o[0], y_o[0], ls_o[0], de_o[0]}, {12'd0, 12'd1, 1'b1, 1'b1});
      wait_t(18399);
      chk("med vsync y22", vs_o[2], 1'b1);
      wait_t(18400);
      chk("med vsync y23", {vs_o[2], x_o[2], y_o[2]}, {1'b0, 12'd0, 12'd23});
      wait_t(19999);
      chk("med vsync y24 end", {vs_o[2], x_o[2], y_o[2]}, {1'b0, 12'd799, 12'd24});
      wait_t(20000);
      chk("med vsync y25", vs_o[2], 1'b1);
      wait_t(22400);
      chk("med frame period", {fs_o[2], x_o[2], y_o[2]}, {1'b1, 12'd0, 12'd0});
      chk("med de count", de_cnt_med, 12800);

      // Asynchronous reset mid-frame, off the clock edge.
      tgt = 22400 + 10 * 800 + 300 + longint'($urandom_range(0, 40));
      wait_t(tgt);
      chk("med pre-reset y", y_o[2], 12'd10);
      #1 rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++)
         chk("async reset", 64'(actual_of(i)), 64'(expect_of(i, 0)));
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 rst = 1'b0;
      wait_t(0);
      chk("restart med", {x_o[2], y_o[2], fs_o[2], de_o[2]}, {12'd0, 12'd0, 1'b1, 1'b1});

      // A few random short resets; the per-cycle compare covers the rest.
      repeat (4) begin
         n = int'($urandom_range(20, 300));
         repeat (n) @(posedge clk);
         #($urandom_range(1, 4)) rst = 1'b1;
         #1;
         chk("rand reset min", 64'(actual_of(1)), 64'(expect_of(1, 0)));
         repeat ($urandom_range(1, 3)) @(posedge clk);
         @(negedge clk);
         #1 rst = 1'b0;
      end
      repeat (1000) @(posedge clk);
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Generates raster timing for the DVI output path: de, hsync/vsync, pixel coordinates and line/frame strobes.
- Sits directly upstream of the DVI generator. de drives its de input; ctrl0 drives its ctrl0 input (ctrl1/ctrl2 tied 0 by the top level).
- Optionally emits an SMPTE-style colour-bar pattern on red/grn/blu for bring-up without a framebuffer.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync width (cycles)
- H_BP, 48, horizontal back porch (cycles)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, hsync active level (0 = active-low)
- VSYNC_POL, 0, vsync active level (0 = active-low)

Ports:
- clk  in  1  pixel clock; the only clock
- rst  in  1  asynchronous, active-high reset
- de  out  1  data enable, high during active pixels
- hsync  out  1  horizontal sync, level set by HSYNC_POL
- vsync  out  1  vertical sync, level set by VSYNC_POL
- ctrl0  out  2  {vsync, hsync}, for the blue-channel control input
- x  out  12  horizontal count, 0..H_TOTAL-1
- y  out  12  vertical count, 0..V_TOTAL-1
- line_start  out  1  one-cycle pulse when x==0
- frame_start  out  1  one-cycle pulse when x==0 and y==0
- red  out  8  pattern red
- grn  out  8  pattern green
- blu  out  8  pattern blue

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined the same way. Both totals must be ≤ 4096; an elaboration-time assertion enforces this. Every parameter must be ≥ 1.
- Horizontal FSM states: H_ACT → H_FP → H_SYN → H_BP → H_ACT. Each state has a down-counter loaded with the state length. The raw x counter increments every cycle and wraps from H_TOTAL-1 to 0.
- Vertical FSM states: V_ACT → V_FP → V_SYN → V_BP → V_ACT. y and the vertical FSM advance only on the cycle where x wraps to 0. y wraps from V_TOTAL-1 to 0.
- Output timing:
  - All outputs are registered from the internal counter/state decode, so they lag the internal counters by exactly 1 cycle.
  - All outputs in the same cycle describe the same (x, y).
- Decode rules:
  - de = (h state H_ACT) && (v state V_ACT).
  - hsync is active while h state is H_SYN.
  - vsync is active for whole lines in V_SYN, i.e. it changes only together with x==0.
- Reset (asynchronous):
  - Internal counters go to (0,0), states to H_ACT/V_ACT.
  - Outputs: de=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, ctrl0 matches, x=y=0, line_start=frame_start=0, red=grn=blu=0.
  - Reset asserted mid-frame clears everything immediately with no completion of the line.
- First edge after rst deasserts: outputs show x=0, y=0, de=1, line_start=1, frame_start=1.
- Boundary cases:
  - Last pixel of frame (x=H_TOTAL-1, y=V_TOTAL-1) is followed directly by (0,0) with frame_start.
  - A state of length 1 lasts exactly one cycle/line.

Optional Feature:
- Macro: VIDEO_TEST_PATTERN_EN.
- With the macro defined:
  - During de, red/grn/blu show 8 vertical bars, each BAR_W = H_ACTIVE/8 pixels wide (integer division). Any remainder pixels belong to the last bar.
  - Bar colour order: white, yellow, cyan, green, magenta, red, blue, black. Each component is FF or 00.
  - The bar index comes from a bar-width counter that resets at x==0; no divider is used.
  - Outputs are 0 whenever de=0.
  - Pattern outputs are registered in the same stage as de.
- Without the macro: red/grn/blu are constant 0 and no pattern logic exists.

Decomposition:
- Package video_pkg holds:
  - enum typedef axis_state_t {ACT, FP, SYN, BP};
  - the default 640x480@60 timing localparams;
  - COORD_W=12;
  - an 8-entry colour-bar constant array.
- Sub-module video_axis_counter contains one axis FSM plus counter, with an advance-enable input and a wrap output. It is instanced for H (enable=1) and V (enable=H wrap).

Test Plan:
- Reset behaviour, defaults: hold rst 5 cycles → de=0, hsync=vsync=1, ctrl0=2'b11. On the first edge after release → x=0, y=0, de=1, frame_start=1.
- Line timing, defaults:
  - de high 640 cycles then low 160.
  - hsync low exactly for x=656..751.
  - line_start period is 800 cycles.
- Frame timing:
  - vsync low for y=490..491, i.e. 1600 cycles, and it transitions only when x==0.
  - frame_start period is 420000 cycles.
  - Total de-high cycles per frame = 307200.
- Minimal parameters: all porch/sync=1, H_ACTIVE=4, V_ACTIVE=2, giving H_TOTAL=7 and V_TOTAL=5.
  - Compare every output cycle-exactly against a reference model over 3 frames.
  - Includes the (6,4) → (0,0) wrap.
- Mid-frame reset: assert rst asynchronously (off-edge) at y=200, x=300 for 2 cycles.
  - Outputs reach reset values before the next clk edge.
  - The timing restarts at (0,0).
- With VIDEO_TEST_PATTERN_EN:
  - (x=0,y=0) → FF/FF/FF; x=80 → FF/FF/00; x=639 → 00/00/00; x=640 (blanking) → 0/0/0.
  - Without the macro, all three outputs are 0 throughout.
